// File: rtl/sw_mode_arbiter.sv
// Switch conditioning: 2-flop sync, per-bit debounce, registered priority encode of SW9..SW1.
// Define MODE_GAP_EN to force an all-off gap of GAP_CYCLES between two non-zero modes.
module sw_mode_arbiter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int GAP_CYCLES      = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] sw_raw,
    output logic [9:0] sw_clean,
    output logic       speed_sel,
    output logic [3:0] mode_code,
    output logic       mode_valid,
    output logic       mode_changed,
    output logic [3:0] digit
);

    localparam logic [3:0] HYPHEN = 4'b1110;

    logic [9:0]       r_syncStage1;
    logic [9:0]       r_syncStage2;
    logic [9:0]       r_clean;
    logic [CNT_W-1:0] r_stableCnt [10];

    logic [3:0] r_modeCode;
    logic       r_modeValid;
    logic       r_modeChanged;
    logic [3:0] r_digit;

    logic [3:0] w_target;
    logic [3:0] w_modeNext;

    // A counter only runs while the synchronised level disagrees with the accepted one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_syncStage1 <= '0;
            r_syncStage2 <= '0;
            r_clean      <= '0;
            for (int i = 0; i < 10; i++) begin
                r_stableCnt[i] <= '0;
            end
        end else begin
            r_syncStage1 <= sw_raw;
            r_syncStage2 <= r_syncStage1;
            for (int i = 0; i < 10; i++) begin
                if (r_syncStage2[i] == r_clean[i]) begin
                    r_stableCnt[i] <= '0;
                end else if (r_stableCnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_clean[i]     <= r_syncStage2[i];
                    r_stableCnt[i] <= '0;
                end else begin
                    r_stableCnt[i] <= r_stableCnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_target = '0;
        for (int i = 1; i <= 9; i++) begin
            if (r_clean[i]) begin
                w_target = 4'(i);
            end
        end
    end

`ifdef MODE_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic {
        IDLE,
        GAP
    } gapState_t;

    gapState_t        r_state;
    gapState_t        w_stateNext;
    logic [GAP_W-1:0] r_gapCnt;
    logic [GAP_W-1:0] w_gapCntNext;

    // On exit from the gap the live target is taken, not the one seen at entry.
    always_comb begin
        w_stateNext  = r_state;
        w_gapCntNext = r_gapCnt;
        w_modeNext   = r_modeCode;
        case (r_state)
            IDLE: begin
                if (w_target != r_modeCode) begin
                    if ((r_modeCode != 4'd0) && (w_target != 4'd0)) begin
                        w_modeNext   = 4'd0;
                        w_gapCntNext = GAP_W'(GAP_CYCLES - 1);
                        w_stateNext  = GAP;
                    end else begin
                        w_modeNext = w_target;
                    end
                end
            end
            GAP: begin
                if (w_target == 4'd0) begin
                    w_stateNext = IDLE;
                end else if (r_gapCnt == '0) begin
                    w_modeNext  = w_target;
                    w_stateNext = IDLE;
                end else begin
                    w_gapCntNext = r_gapCnt - 1'b1;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end
`else
    assign w_modeNext = w_target;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_modeCode    <= 4'd0;
            r_modeValid   <= 1'b0;
            r_modeChanged <= 1'b0;
            r_digit       <= HYPHEN;
`ifdef MODE_GAP_EN
            r_state       <= IDLE;
            r_gapCnt      <= '0;
`endif
        end else begin
            r_modeCode    <= w_modeNext;
            r_modeValid   <= (w_modeNext != 4'd0);
            r_modeChanged <= (w_modeNext != r_modeCode);
            r_digit       <= (w_modeNext != 4'd0) ? w_modeNext : HYPHEN;
`ifdef MODE_GAP_EN
            r_state       <= w_stateNext;
            r_gapCnt      <= w_gapCntNext;
`endif
        end
    end

    assign sw_clean     = r_clean;
    assign speed_sel    = r_clean[0];
    assign mode_code    = r_modeCode;
    assign mode_valid   = r_modeValid;
    assign mode_changed = r_modeChanged;
    assign digit        = r_digit;

endmodule

// File: tb/tb_sw_mode_arbiter.sv
// Bench for sw_mode_arbiter: directed test-plan steps then random switch traffic,
// checked every cycle against a history-window model of debounce and mode selection.
module tb_sw_mode_arbiter;

    localparam int D   = 4;
    localparam int CW  = 3;
    localparam int GAP = 3;
`ifdef MODE_GAP_EN
    localparam int PULSES_PER_SWAP = 2;
    localparam int ZERO_PER_SWAP   = GAP;
`else
    localparam int PULSES_PER_SWAP = 1;
    localparam int ZERO_PER_SWAP   = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sw_raw = '0;
    logic [9:0] sw_clean;
    logic       speed_sel;
    logic [3:0] mode_code;
    logic       mode_valid;
    logic       mode_changed;
    logic [3:0] digit;

    sw_mode_arbiter #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(CW),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_raw(sw_raw),
        .sw_clean(sw_clean),
        .speed_sel(speed_sel),
        .mode_code(mode_code),
        .mode_valid(mode_valid),
        .mode_changed(mode_changed),
        .digit(digit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulseCount = 0;
    int zeroCycles = 0;

    logic [9:0] hist[$];
    logic [9:0] mClean;
    logic [3:0] mMode;
    logic       mChanged;
    int         mGapLeft;

    function automatic logic [3:0] encode(logic [9:0] c);
        for (int i = 9; i >= 1; i--) begin
            if (c[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    // A bit flips once the last D synchronised samples all disagree with its accepted level.
    task automatic modelEdge(input logic [9:0] raw, input logic rstn);
        logic [3:0] target;
        logic [3:0] newMode;
        logic [9:0] nextClean;
        logic       allDiff;
        if (!rstn) begin
            hist.delete();
            for (int j = 0; j < D + 2; j++) hist.push_back('0);
            mClean   = '0;
            mMode    = 4'd0;
            mChanged = 1'b0;
            mGapLeft = -1;
            return;
        end
        target    = encode(mClean);
        nextClean = mClean;
        for (int b = 0; b < 10; b++) begin
            allDiff = 1'b1;
            for (int j = 0; j < D; j++) begin
                if (hist[hist.size() - 2 - j][b] == mClean[b]) allDiff = 1'b0;
            end
            if (allDiff) nextClean[b] = ~mClean[b];
        end
        hist.push_back(raw);
        void'(hist.pop_front());
`ifdef MODE_GAP_EN
        if (mGapLeft < 0) begin
            if (target != mMode && mMode != 0 && target != 0) begin
                newMode  = 4'd0;
                mGapLeft = GAP - 1;
            end else begin
                newMode = target;
            end
        end else begin
            newMode = 4'd0;
            if (target == 0) mGapLeft = -1;
            else if (mGapLeft == 0) begin
                newMode  = target;
                mGapLeft = -1;
            end else mGapLeft = mGapLeft - 1;
        end
`else
        newMode = target;
`endif
        mChanged = (newMode != mMode);
        mMode    = newMode;
        mClean   = nextClean;
    endtask

    task automatic checkVal(input string tag, input logic [9:0] observed, input logic [9:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        checkVal("sw_clean", sw_clean, mClean);
        checkVal("speed_sel", 10'(speed_sel), 10'(mClean[0]));
        checkVal("mode_code", 10'(mode_code), 10'(mMode));
        checkVal("mode_valid", 10'(mode_valid), 10'(mMode != 0));
        checkVal("mode_changed", 10'(mode_changed), 10'(mChanged));
        checkVal("digit", 10'(digit), (mMode != 0) ? 10'(mMode) : 10'h00E);
    endtask

    task automatic applyStimulus(input logic [9:0] raw, input logic rstn, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            sw_raw = raw;
            rst_n  = rstn;
            @(posedge clk);
            #1;
            modelEdge(raw, rstn);
            checkOutput();
            pulseCount += int'(mode_changed);
            if (mode_code == 4'd0) zeroCycles++;
        end
    endtask

    initial begin
        logic [9:0] rv;
        logic [5:0] bounce;

        applyStimulus(10'h3FF, 1'b0, 3);
        checkVal("reset_digit", 10'(digit), 10'h00E);
        checkVal("reset_clean", sw_clean, 10'h000);
        applyStimulus(10'h3FF, 1'b1, 5);
        checkVal("clean_edge5", sw_clean, 10'h000);
        applyStimulus(10'h3FF, 1'b1, 1);
        checkVal("clean_edge6", sw_clean, 10'h3FF);
        checkVal("mode_edge6", 10'(mode_code), 10'd0);
        applyStimulus(10'h3FF, 1'b1, 1);
        checkVal("mode_edge7", 10'(mode_code), 10'd9);
        applyStimulus(10'h000, 1'b1, 12);

        pulseCount = 0;
        applyStimulus(10'h020, 1'b1, 3);
        applyStimulus(10'h000, 1'b1, 10);
        checkVal("glitch_clean5", 10'(sw_clean[5]), 10'd0);
        checkVal("glitch_pulses", 10'(pulseCount), 10'd0);

        pulseCount = 0;
        bounce = 6'b111101;
        for (int k = 0; k < 6; k++) applyStimulus(bounce[k] ? 10'h080 : 10'h000, 1'b1, 1);
        applyStimulus(10'h080, 1'b1, 8);
        checkVal("bounce_mode", 10'(mode_code), 10'd7);
        checkVal("bounce_digit", 10'(digit), 10'd7);
        checkVal("bounce_pulses", 10'(pulseCount), 10'd1);

        applyStimulus(10'h108, 1'b1, 12);
        checkVal("prio_mode8", 10'(mode_code), 10'd8);
        pulseCount = 0;
        applyStimulus(10'h008, 1'b1, 12);
        checkVal("prio_mode3", 10'(mode_code), 10'd3);
        checkVal("prio_pulses", 10'(pulseCount), 10'(PULSES_PER_SWAP));
        applyStimulus(10'h000, 1'b1, 12);
        checkVal("prio_mode0", 10'(mode_code), 10'd0);
        checkVal("prio_digit0", 10'(digit), 10'h00E);
        checkVal("prio_valid0", 10'(mode_valid), 10'd0);

        pulseCount = 0;
        applyStimulus(10'h001, 1'b1, 5);
        checkVal("speed_edge5", 10'(speed_sel), 10'd0);
        applyStimulus(10'h001, 1'b1, 1);
        checkVal("speed_edge6", 10'(speed_sel), 10'd1);
        applyStimulus(10'h001, 1'b1, 6);
        checkVal("speed_mode", 10'(mode_code), 10'd0);
        checkVal("speed_pulses", 10'(pulseCount), 10'd0);

        applyStimulus(10'h200, 1'b1, 12);
        applyStimulus(10'h210, 1'b1, 12);
        checkVal("swap_mode9", 10'(mode_code), 10'd9);
        pulseCount = 0;
        zeroCycles = 0;
        applyStimulus(10'h010, 1'b1, 12);
        checkVal("swap_mode4", 10'(mode_code), 10'd4);
        checkVal("swap_pulses", 10'(pulseCount), 10'(PULSES_PER_SWAP));
        checkVal("swap_zero_cycles", 10'(zeroCycles), 10'(ZERO_PER_SWAP));

        for (int s = 0; s < 300; s++) begin
            rv = 10'($urandom);
            if ($urandom_range(0, 24) == 0) applyStimulus(rv, 1'b0, $urandom_range(1, 2));
            else applyStimulus(rv, 1'b1, $urandom_range(1, 9));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
